// File: rtl/bike_display_sequencer_if.sv
// Formatter handshake between the display sequencer (master) and the external
// ASCII formatter (slave).
interface bike_display_sequencer_if #(
    parameter int NUM_MODES = 4,
    parameter int DIGITS    = 6
);
    logic                   fmt_start;
    logic [NUM_MODES-1:0]   fmt_mode;
    logic                   fmt_valid;
    logic [8*DIGITS-1:0]    fmt_data;

    modport master (output fmt_start, output fmt_mode, input fmt_valid, input fmt_data);
    modport slave  (input fmt_start, input fmt_mode, output fmt_valid, output fmt_data);
endinterface

// File: rtl/bike_display_sequencer.sv
// Bike computer display/mode controller: button-driven one-hot mode rotation,
// long-press trip clear, overspeed/motion flags and a coalescing formatter refresh.
module bike_display_sequencer #(
    parameter int NUM_MODES      = 4,
    parameter int SPEED_WIDTH    = 7,
    parameter int DIGITS         = 6,
    parameter int OVERSPEED_KMH  = 65,
    parameter int OVERSPEED_HYST = 3,
    parameter int MOVE_MIN_KMH   = 6,
    parameter int LONG_PRESS_SEC = 2,
    parameter int TIMEOUT_CYC    = 1024,
    parameter logic [NUM_MODES-1:0] POINT_MASK = 4'b0011,
    parameter logic [NUM_MODES-1:0] COLON_MASK = 4'b0100
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    mode_btn,
    input  logic                    half_sec_pulse,
    input  logic                    sec_pulse,
    input  logic [SPEED_WIDTH-1:0]  speed,
    output logic [NUM_MODES-1:0]    mode_onehot,
    output logic [NUM_MODES-1:0]    mode_ind,
    output logic                    overspeed,
    output logic                    en_move,
    output logic                    trip_clear,
    bike_display_sequencer_if.master fmt,
    output logic [8*DIGITS-1:0]     disp_data,
    output logic                    point,
    output logic                    col,
    output logic                    fmt_timeout
);
    localparam int HW = $clog2(LONG_PRESS_SEC + 1);
    localparam int TW = $clog2(TIMEOUT_CYC);
    localparam logic [HW-1:0] HOLD_MAX = HW'(LONG_PRESS_SEC);
    localparam logic [HW-1:0] HOLD_PRE = HW'(LONG_PRESS_SEC - 1);
    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYC - 1);
    localparam logic [SPEED_WIDTH-1:0] OS_SET   = SPEED_WIDTH'(OVERSPEED_KMH);
    localparam logic [SPEED_WIDTH-1:0] OS_CLR   = SPEED_WIDTH'(OVERSPEED_KMH - OVERSPEED_HYST);
    localparam logic [SPEED_WIDTH-1:0] MOVE_MIN = SPEED_WIDTH'(MOVE_MIN_KMH);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } ref_state_t;

    ref_state_t     state_r;
    logic           btn_r;
    logic [HW-1:0]  hold_r;
    logic           long_r;
    logic           mode_chg_r;
    logic           blink_r;
    logic           pending_r;
    logic [TW-1:0]  timer_r;
    logic           rise_s;
    logic           fall_s;
    logic           req_s;

    assign rise_s = mode_btn & ~btn_r;
    assign fall_s = ~mode_btn & btn_r;
    // Mode change and trip clear are one cycle late so the new mode is already visible.
    assign req_s  = sec_pulse | mode_chg_r | trip_clear;

    // Button edge tracking, long-press timing and mode rotation
    always_ff @(posedge clock) begin
        if (reset) begin
            btn_r       <= 1'b0;
            hold_r      <= {HW{1'b0}};
            long_r      <= 1'b0;
            trip_clear  <= 1'b0;
            mode_chg_r  <= 1'b0;
            mode_onehot <= NUM_MODES'(1);
        end else begin
            btn_r      <= mode_btn;
            trip_clear <= 1'b0;
            mode_chg_r <= 1'b0;
            if (rise_s) begin
                hold_r <= {HW{1'b0}};
            end else if (mode_btn && sec_pulse && (hold_r != HOLD_MAX)) begin
                hold_r <= hold_r + HW'(1);
                if (hold_r == HOLD_PRE) begin
                    trip_clear <= 1'b1;
                    long_r     <= 1'b1;
                end
            end
            if (fall_s) begin
                long_r <= 1'b0;
                if (!long_r) begin
                    mode_onehot <= {mode_onehot[NUM_MODES-2:0], mode_onehot[NUM_MODES-1]};
                    mode_chg_r  <= 1'b1;
                end
            end
        end
    end

    // Blink phase, overspeed hysteresis, motion enable and mode indicator
    always_ff @(posedge clock) begin
        if (reset) begin
            blink_r   <= 1'b0;
            overspeed <= 1'b0;
            en_move   <= 1'b0;
            mode_ind  <= NUM_MODES'(1);
        end else begin
            if (half_sec_pulse) begin
                blink_r <= ~blink_r;
            end
            if (speed > OS_SET) begin
                overspeed <= 1'b1;
            end else if (speed <= OS_CLR) begin
                overspeed <= 1'b0;
            end
            en_move  <= (speed >= MOVE_MIN);
            mode_ind <= mode_onehot | ((overspeed & blink_r) ? ~mode_onehot : {NUM_MODES{1'b0}});
        end
    end

    // Formatter refresh handshake with request coalescing and timeout
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r       <= ST_IDLE;
            pending_r     <= 1'b0;
            timer_r       <= {TW{1'b0}};
            fmt.fmt_start <= 1'b0;
            fmt.fmt_mode  <= NUM_MODES'(1);
            fmt_timeout   <= 1'b0;
            disp_data     <= {DIGITS{8'h20}};
            point         <= 1'b0;
            col           <= 1'b0;
        end else begin
            fmt.fmt_start <= 1'b0;
            fmt_timeout   <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (req_s || pending_r) begin
                        fmt.fmt_start <= 1'b1;
                        fmt.fmt_mode  <= mode_onehot;
                        pending_r     <= 1'b0;
                        timer_r       <= {TW{1'b0}};
                        state_r       <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    timer_r <= timer_r + TW'(1);
                    if (req_s) begin
                        pending_r <= 1'b1;
                    end
                    if (fmt.fmt_valid) begin
                        disp_data <= fmt.fmt_data;
                        point     <= |(fmt.fmt_mode & POINT_MASK);
                        col       <= (|(fmt.fmt_mode & COLON_MASK)) ? ~col : 1'b0;
                        state_r   <= ST_IDLE;
                    end else if (timer_r == TIMER_LAST) begin
                        fmt_timeout <= 1'b1;
                        state_r     <= ST_IDLE;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end
endmodule
